// File: rtl/regfile_display_scheduler_if.sv
// rtl/regfile_display_scheduler_if.sv - read-port sharing bus between CPU, register file and display scanner
//
// Signals:
//   cpu_rd_req  : CPU wants the register-file read port this cycle
//   cpu_rd_addr : CPU read address
//   cpu_rd_data : read data returned to the CPU (mirror of rf_rd_data)
//   cpu_stall   : CPU must hold its state this cycle
//   rf_rd_addr  : address presented to the register-file read port
//   rf_rd_data  : combinational register-file read data
// Modports:
//   master : CPU + register-file side (drives requests and read data)
//   slave  : scheduler side (drives the muxed address, data mirror and stall)
interface regfile_display_scheduler_if;
  logic        cpu_rd_req;
  logic [4:0]  cpu_rd_addr;
  logic [31:0] cpu_rd_data;
  logic        cpu_stall;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  modport master (
    output cpu_rd_req,
    output cpu_rd_addr,
    output rf_rd_data,
    input  cpu_rd_data,
    input  cpu_stall,
    input  rf_rd_addr
  );

  modport slave (
    input  cpu_rd_req,
    input  cpu_rd_addr,
    input  rf_rd_data,
    output cpu_rd_data,
    output cpu_stall,
    output rf_rd_addr
  );
endinterface

// File: rtl/regfile_display_scheduler.sv
// rtl/regfile_display_scheduler.sv - periodic register-file scanner driving four BCD / seven-segment digits
//
// Steals one register-file read cycle every SCAN_PERIOD idle cycles, saturates the
// captured value at 9999, converts it with a sequential 14-bit double-dabble and
// updates the digit, segment and saturation outputs.
//
// Optional feature macro: REGFILE_SCAN_STALL_EN
//   defined   : after MAX_WAIT ungranted REQ cycles the scanner is forced in and
//               cpu_stall pulses for that single grant cycle
//   undefined : CPU always wins, cpu_stall is tied low
//
// Ports:
//   i_clk           : clock
//   i_reset         : synchronous active-high reset
//   io_bus          : read-port sharing bus (slave modport)
//   i_sel_reg       : register index to display, sampled on the grant cycle
//   o_tho..o_one    : BCD digits (thousands..ones)
//   o_thossd..o_onessd : active-low segments, bit6..0 = g..a
//   o_led_indicator : displayed value was saturated
module regfile_display_scheduler #(
  parameter int SCAN_PERIOD = 50000,
  parameter int MAX_WAIT    = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  regfile_display_scheduler_if.slave    io_bus,
  input  logic [4:0]                    i_sel_reg,
  output logic [3:0]                    o_tho,
  output logic [3:0]                    o_hun,
  output logic [3:0]                    o_ten,
  output logic [3:0]                    o_one,
  output logic [6:0]                    o_thossd,
  output logic [6:0]                    o_hunssd,
  output logic [6:0]                    o_tenssd,
  output logic [6:0]                    o_onessd,
  output logic                          o_led_indicator
);

  if (SCAN_PERIOD < 2 || MAX_WAIT < 1) begin : g_bad_params
    $error("regfile_display_scheduler: SCAN_PERIOD must be >= 2 and MAX_WAIT >= 1");
  end

  // Timer only ever holds SCAN_PERIOD-1 down to 0.
  localparam int TW = $clog2(SCAN_PERIOD);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CONV,
    S_UPDATE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [TW-1:0] r_timer;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [15:0] w_bcd_adj;
  logic [3:0]  r_cnt;
  logic        r_sat;
  logic        w_over;
  logic        w_grant;
  logic        w_stall;
  logic        w_forced;
  logic [4:0]  w_rf_rd_addr;

  logic [3:0]  r_tho, r_hun, r_ten, r_one;
  logic [6:0]  r_thossd, r_hunssd, r_tenssd, r_onessd;
  logic        r_led;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

`ifdef REGFILE_SCAN_STALL_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] r_wait;

  // Held at zero outside REQ, so it is clear on every REQ entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait <= '0;
    end else if (r_state != S_REQ) begin
      r_wait <= '0;
    end else if (!w_grant) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_forced = (r_wait == WW'(MAX_WAIT));
`else
  assign w_forced = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (r_timer == '0) w_next_state = S_REQ;
      S_REQ:    if (w_grant) w_next_state = S_CONV;
      S_CONV:   if (r_cnt == 4'd13) w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: grant, stall and read-port mux are all combinational.
  always_comb begin
    w_grant      = 1'b0;
    w_stall      = 1'b0;
    w_rf_rd_addr = io_bus.cpu_rd_addr;
    if (r_state == S_REQ) begin
      w_grant = !io_bus.cpu_rd_req || w_forced;
      w_stall = io_bus.cpu_rd_req && w_forced;
      if (w_grant) w_rf_rd_addr = i_sel_reg;
    end
  end

  assign w_over = (io_bus.rf_rd_data > 32'd9999);

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer  <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_tho    <= '0;
      r_hun    <= '0;
      r_ten    <= '0;
      r_one    <= '0;
      r_thossd <= SEG_ZERO;
      r_hunssd <= SEG_ZERO;
      r_tenssd <= SEG_ZERO;
      r_onessd <= SEG_ZERO;
      r_led    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= (r_timer == '0) ? TW'(SCAN_PERIOD - 1) : r_timer - 1'b1;
        end
        S_REQ: begin
          if (w_grant) begin
            r_bin <= w_over ? 14'd9999 : io_bus.rf_rd_data[13:0];
            r_sat <= w_over;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
        end
        S_UPDATE: begin
          r_tho    <= r_bcd[15:12];
          r_hun    <= r_bcd[11:8];
          r_ten    <= r_bcd[7:4];
          r_one    <= r_bcd[3:0];
          r_thossd <= seg7(r_bcd[15:12]);
          r_hunssd <= seg7(r_bcd[11:8]);
          r_tenssd <= seg7(r_bcd[7:4]);
          r_onessd <= seg7(r_bcd[3:0]);
          r_led    <= r_sat;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.rf_rd_addr  = w_rf_rd_addr;
  assign io_bus.cpu_rd_data = io_bus.rf_rd_data;
  assign io_bus.cpu_stall   = w_stall;

  assign o_tho           = r_tho;
  assign o_hun           = r_hun;
  assign o_ten           = r_ten;
  assign o_one           = r_one;
  assign o_thossd        = r_thossd;
  assign o_hunssd        = r_hunssd;
  assign o_tenssd        = r_tenssd;
  assign o_onessd        = r_onessd;
  assign o_led_indicator = r_led;

endmodule

// File: tb/tb_regfile_display_scheduler.sv
// tb/tb_regfile_display_scheduler.sv - scoreboard bench for regfile_display_scheduler
module tb_regfile_display_scheduler;
  localparam int SP = 16;
  localparam int MW = 255;
`ifdef REGFILE_SCAN_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] tho, hun, ten, one;
    logic [6:0] s3, s2, s1, s0;
    logic       led;
  } disp_t;

  typedef struct {
    int    cyc;
    disp_t v;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sel_reg;
  logic [3:0]  tho, hun, ten, one;
  logic [6:0]  thossd, hunssd, tenssd, onessd;
  logic        led;
  logic [31:0] rf_mem [32];
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  sb_t         sb [$];

  regfile_display_scheduler_if bus ();

  assign bus.rf_rd_data = rf_mem[bus.rf_rd_addr];

  regfile_display_scheduler #(.SCAN_PERIOD(SP), .MAX_WAIT(MW)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .io_bus          (bus),
    .i_sel_reg       (sel_reg),
    .o_tho           (tho),
    .o_hun           (hun),
    .o_ten           (ten),
    .o_one           (one),
    .o_thossd        (thossd),
    .o_hunssd        (hunssd),
    .o_tenssd        (tenssd),
    .o_onessd        (onessd),
    .o_led_indicator (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic disp_t reset_disp();
    disp_t r;
    r = '0;
    r.s3 = 7'b1000000; r.s2 = 7'b1000000; r.s1 = 7'b1000000; r.s0 = 7'b1000000;
    return r;
  endfunction

  // Decimal reference: clamp to 9999, split by division.
  function automatic disp_t model(input logic [31:0] v);
    disp_t r;
    int unsigned n;
    n = (v > 32'd9999) ? 9999 : int'(v);
    r.tho = 4'(n / 1000);
    r.hun = 4'((n / 100) % 10);
    r.ten = 4'((n / 10) % 10);
    r.one = 4'(n % 10);
    r.s3 = seg_tab[r.tho]; r.s2 = seg_tab[r.hun]; r.s1 = seg_tab[r.ten]; r.s0 = seg_tab[r.one];
    r.led = (v > 32'd9999);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random_cpu();
    bus.cpu_rd_req  = 1'($urandom_range(0, 1));
    bus.cpu_rd_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic chk_port(input string name, input logic exp_stall);
    #1;
    chk({name, "_rf_addr"}, 64'(bus.rf_rd_addr), 64'(bus.cpu_rd_addr));
    chk({name, "_cpu_data"}, 64'(bus.cpu_rd_data), 64'(rf_mem[bus.cpu_rd_addr]));
    chk({name, "_stall"}, 64'(bus.cpu_stall), 64'(exp_stall));
  endtask

  // Entered at the first cycle of REQ. w = cycles the CPU holds the port.
  task automatic scan(input int w, input logic [4:0] idx, input logic [31:0] val, input int abort_at);
    int gi;
    int g;
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'd0 : val;
    if (idx != 5'd0) rf_mem[idx] = val;
    sel_reg = idx;
    gi = (STALL_EN && w > MW) ? MW : w;
    for (int i = 0; i < gi; i++) begin
      bus.cpu_rd_req  = 1'b1;
      bus.cpu_rd_addr = 5'($urandom_range(0, 31));
      chk_port("req_wait", 1'b0);
      step();
    end
    bus.cpu_rd_req  = (gi < w);
    bus.cpu_rd_addr = idx ^ 5'($urandom_range(1, 31));
    #1;
    chk("grant_rf_addr", 64'(bus.rf_rd_addr), 64'(idx));
    chk("grant_stall", 64'(bus.cpu_stall), 64'(STALL_EN && gi < w));
    g = cyc;
    sb.push_back('{cyc: g + 16, v: model(v)});
    if (abort_at > 0) begin
      for (int k = 0; k < abort_at; k++) begin
        step();
        drive_random_cpu();
        chk_port("conv", 1'b0);
      end
      reset = 1'b1;
      sb.delete();
      sb.push_back('{cyc: cyc + 1, v: reset_disp()});
      step();
      drive_random_cpu();
      chk_port("mid_reset", 1'b0);
      step();
      reset = 1'b0;
      step();
    end else begin
      for (int k = 0; k < 16 + SP; k++) begin
        step();
        if (k == 15 + SP) break;
        drive_random_cpu();
        chk_port("post_grant", 1'b0);
      end
    end
  endtask

  // Monitor: pops expected displays at their due cycle; any other output change is an error.
  initial begin
    disp_t act, prev;
    bit armed;
    armed = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      act = {tho, hun, ten, one, thossd, hunssd, tenssd, onessd, led};
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_entry: due cycle %0d, now %0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sb_t e;
        e = sb.pop_front();
        chk("display", 64'(act), 64'(e.v));
        armed = 1'b1;
        prev = act;
      end else if (armed) begin
        chk("display_hold", 64'(act), 64'(prev));
        prev = act;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rv;
    logic [4:0]  ri;
    foreach (rf_mem[i]) rf_mem[i] = $urandom;
    rf_mem[0] = 32'd0;
    reset = 1'b1;
    sel_reg = 5'd0;
    bus.cpu_rd_req = 1'b0;
    bus.cpu_rd_addr = 5'd0;
    sb.push_back('{cyc: 1, v: reset_disp()});
    step();
    drive_random_cpu();
    chk_port("reset", 1'b0);
    step();
    reset = 1'b0;
    bus.cpu_rd_req = 1'b0;
    step();

    scan(0, 5'd5, 32'd1234, 0);
    scan(0, 5'd9, 32'd70000, 0);
    scan(100, 5'd7, 32'd4321, 0);
    scan(0, 5'd3, 32'd42, 0);
    scan(0, 5'd3, 32'd917, 0);
    scan(0, 5'd12, 32'd555, 7);
    scan(20, 5'd12, 32'd8, 0);
    scan(1000, 5'd20, 32'd65535, 0);
    for (int n = 0; n < 8; n++) begin
      ri = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = 32'($urandom_range(0, 9999));
        2: rv = 32'd9999;
        default: rv = 32'd10000;
      endcase
      scan(int'($urandom_range(0, 5)), ri, rv, 0);
    end

    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
